sobel_window_ctrl: RTL

Streaming front-end controller for the Sobel edge path. It accepts one grayscale pixel per handshake in raster order. Two internal line buffers and a 3x3 shift window assemble each neighbourhood, and the block presents a registered `sobel_matrix` plus valid to the combinational Sobel core. It sequences each frame through fill, stream and done phases, applies backpressure, and flags frame boundaries.

---
 rtl/sobel_window_ctrl_if.sv | 25 ++
 rtl/sobel_window_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle for sobel_window_ctrl.
// matrix_o[k][j] is vector<k>.pix<j>: k=0 top (oldest) row, j=0 left column.
interface sobel_window_ctrl_if #(
   parameter int unsigned PIXEL_WIDTH = 8
);
   logic                               start_i;
   logic [PIXEL_WIDTH-1:0]             pix_i;
   logic                               pix_valid_i;
   logic                               pix_ready_o;
   logic [2:0][2:0][PIXEL_WIDTH-1:0]   matrix_o;
   logic                               matrix_valid_o;
   logic                               matrix_ready_i;
   logic                               busy_o;
   logic                               frame_done_o;

   modport slave (
      input  start_i, pix_i, pix_valid_i, matrix_ready_i,
      output pix_ready_o, matrix_o, matrix_valid_o, busy_o, frame_done_o
   );

   modport master (
      output start_i, pix_i, pix_valid_i, matrix_ready_i,
      input  pix_ready_o, matrix_o, matrix_valid_o, busy_o, frame_done_o
   );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Raster-order pixel stream to 3x3 Sobel neighbourhoods via two line buffers
// and a shift window; emits interior windows only, one frame per start.
module sobel_window_ctrl #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned IMG_WIDTH   = 160,
   parameter int unsigned IMG_HEIGHT  = 120
) (
   input logic                clk_i,
   input logic                rst_i,
   sobel_window_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

   state_e                            state_q, state_d;
   logic [CW-1:0]                     col_q, col_d;
   logic [RW-1:0]                     row_q, row_d;
   logic                              all_in_q, all_in_d;
   logic                              mv_q, mv_d;
   logic [2:0][2:0][PIXEL_WIDTH-1:0]  win_q, win_d;
   logic [PIXEL_WIDTH-1:0]            lb0_q [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0]            lb1_q [IMG_WIDTH];

   logic accept, emit, col_last, row_last, last_hs, pix_ready;

   assign col_last = (col_q == CW'(IMG_WIDTH - 1));
   assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
   assign pix_ready = ((state_q == FILL) || (state_q == STREAM)) && !all_in_q &&
                      (!mv_q || bus.matrix_ready_i);
   assign accept   = bus.pix_valid_i && pix_ready;
   assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
   // The final window is the only one still held once every pixel is in.
   assign last_hs  = all_in_q && mv_q && bus.matrix_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start_i) state_d = FILL;
         FILL:    if (accept && (row_q == RW'(2)) && (col_q == '0)) state_d = STREAM;
         STREAM:  if (last_hs) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.pix_ready_o  = pix_ready;
      bus.busy_o       = (state_q != IDLE);
      bus.frame_done_o = (state_q == DONE);
   end

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      all_in_d = all_in_q;
      win_d    = win_q;
      mv_d     = mv_q;
      if ((state_q == IDLE) && bus.start_i) begin
         col_d    = '0;
         row_d    = '0;
         all_in_d = 1'b0;
      end
      if (accept) begin
         for (int unsigned k = 0; k < 3; k++) begin
            win_d[k][0] = win_q[k][1];
            win_d[k][1] = win_q[k][2];
         end
         win_d[0][2] = lb0_q[col_q];
         win_d[1][2] = lb1_q[col_q];
         win_d[2][2] = bus.pix_i;
         if (col_last) begin
            col_d = '0;
            if (!row_last) row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (col_last && row_last) all_in_d = 1'b1;
      end
      if (emit)                     mv_d = 1'b1;
      else if (bus.matrix_ready_i)  mv_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q    <= '0;
         row_q    <= '0;
         all_in_q <= 1'b0;
         mv_q     <= 1'b0;
         win_q    <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         all_in_q <= all_in_d;
         mv_q     <= mv_d;
         win_q    <= win_d;
      end
   end

   // Line buffers are never cleared; rows 0..1 are rewritten before any emitted window uses them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb0_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= bus.pix_i;
      end
   end

   assign bus.matrix_o       = win_q;
   assign bus.matrix_valid_o = mv_q;
endmodule
